// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// default widths, reset PC and the sequential PC stride.
// No logic, no latency, no backpressure.
package ifu_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF   = 64;
    localparam int unsigned INST_W_DEF   = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    // Fixed-length 32-bit instructions: sequential fetch advances by 4 bytes.
    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // not fetching; waiting for fetch_en
        ST_REQ  = 2'd1,  // request presented to IMEM, waiting for ready
        ST_WAIT = 2'd2,  // request accepted, waiting for the response
        ST_HOLD = 2'd3   // instruction presented to decode, waiting for ready
    } fetch_state_e;

    // A redirect target whose low two bits are set cannot be an
    // instruction boundary; it is flagged and then force-aligned.
    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one IMEM read at a
// time and hands the result to decode. Req handshake to inst_valid is >= 2 cycles.
// Backpressure: decode stall holds the instruction in HOLD; no new request until accepted.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   fetch_en            permission to start new IMEM requests
//   redirect_valid/pc   branch/jump target from execute; highest priority
//   imem_req_*          IMEM read request (valid/ready), address = pc_o
//   imem_rsp_*          IMEM read response (no backpressure), err = access fault
//   inst_*              instruction to decode (valid/ready) with its PC and fault flag
//   misalign_o          one-cycle pulse after a redirect with nonzero low bits
//   pc_o                current fetch PC
//   fetch_cnt           number of instructions accepted by decode (wraps)
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned          INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [63:0]       fetch_cnt
);

    fetch_state_e      state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    // Set when the request currently in flight is on a squashed path; its
    // response is dropped when it eventually arrives.
    logic              kill_q, kill_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_fault_q, inst_fault_d;
    logic              misalign_q, misalign_d;
    logic [63:0]       cnt_q, cnt_d;

    logic [ADDR_W-1:0] redirect_aligned;
    logic              req_fire;
    logic              rsp_keep;
    logic              dec_accept;

    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign req_fire         = (state_q == ST_REQ) && imem_req_ready;
    // A response survives only if nothing squashed it earlier and no redirect
    // lands in the very cycle it arrives.
    assign rsp_keep         = (state_q == ST_WAIT) && imem_rsp_valid &&
                              !kill_q && !redirect_valid;
    assign dec_accept       = (state_q == ST_HOLD) && inst_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The request is never retracted, even if fetch_en drops.
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        state_d = fetch_en ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Either decode took it, or a redirect made it wrong-path.
                if (inst_ready || redirect_valid) begin
                    state_d = fetch_en ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore outputs from state)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state_q)
            ST_REQ:  imem_req_valid = 1'b1;
            ST_HOLD: inst_valid     = 1'b1;
            default: begin
                imem_req_valid = 1'b0;
                inst_valid     = 1'b0;
            end
        endcase
    end

    assign imem_req_addr = pc_q;
    assign pc_o          = pc_q;
    assign inst_o        = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_fault    = inst_fault_q;
    assign misalign_o    = misalign_q;
    assign fetch_cnt     = cnt_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        cnt_d        = cnt_q;
        misalign_d   = redirect_valid && pc_misaligned(redirect_pc[1:0]);

        // Decode acceptance counts even when a redirect arrives alongside it;
        // the redirect below then overrides the sequential PC.
        if (dec_accept) begin
            cnt_d = cnt_q + 64'd1;
            pc_d  = pc_q + ADDR_W'(PC_INC);
        end

        // The old-address request is launched this cycle; mark it stale.
        if (req_fire && redirect_valid) begin
            kill_d = 1'b1;
        end

        if (state_q == ST_WAIT) begin
            if (imem_rsp_valid) begin
                kill_d = 1'b0;
            end else if (redirect_valid) begin
                kill_d = 1'b1;
            end
        end

        // pc_q still holds the requested address while in WAIT, since any
        // redirect that could have moved it also marks the response stale.
        if (rsp_keep) begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_rsp_err;
        end

        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            misalign_q   <= misalign_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;
    import ifu_fetch_ctrl_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        misalign_o;
    logic [63:0] pc_o;
    logic [63:0] fetch_cnt;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(
        .ADDR_W   (64),
        .INST_W   (32),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .misalign_o     (misalign_o),
        .pc_o           (pc_o),
        .fetch_cnt      (fetch_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_inst_t;

    // Scoreboard queues filled by the stimulus/model, drained by the monitor.
    exp_inst_t   exp_inst_q[$];
    logic [63:0] exp_addr_q[$];
    logic        exp_mis_q[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [63:0] mon_acc;

    // Reference model: architectural fetch PC plus the one IMEM transaction.
    logic [63:0] m_pc;
    bit          out_busy;
    bit          out_killed;
    int          out_lat;
    logic [63:0] out_addr;

    // Stimulus knobs (percentages / max latency).
    int p_redir, p_rdy, lat_max, p_irdy, p_fen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_checks();
        chk("rst_req_valid",  {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid},     64'd0);
        chk("rst_pc",         pc_o,                    RPC);
        chk("rst_req_addr",   imem_req_addr,           RPC);
        chk("rst_inst",       {32'd0, inst_o},         64'd0);
        chk("rst_inst_pc",    inst_pc,                 64'd0);
        chk("rst_fault",      {63'd0, inst_fault},     64'd0);
        chk("rst_misalign",   {63'd0, misalign_o},     64'd0);
        chk("rst_fetch_cnt",  fetch_cnt,               64'd0);
    endtask

    task automatic model_reset();
        exp_inst_q.delete();
        exp_addr_q.delete();
        exp_mis_q.delete();
        // One entry for the release cycle, one for the cycle after it.
        exp_mis_q.push_back(1'b0);
        exp_mis_q.push_back(1'b0);
        mon_acc    = 64'd0;
        m_pc       = RPC;
        out_busy   = 1'b0;
        out_killed = 1'b0;
        out_lat    = 0;
        out_addr   = 64'd0;
    endtask

    // One cycle of stimulus, called at a falling edge. Handshakes that will
    // complete at the next rising edge are decided here from DUT valids and
    // the readies driven now.
    task automatic step();
        bit          rv;
        logic [63:0] rp;
        bit          rsp;
        logic [31:0] d;
        bit          e;
        bit          fire;
        bit          ihs;
        rv = ($urandom_range(0, 99) < p_redir);
        if ($urandom_range(0, 3) == 0)
            rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        else
            rp = RPC + 64'($urandom_range(0, 16'hFFFF));
        d   = $urandom;
        e   = ($urandom_range(0, 7) == 0);
        rsp = 1'b0;
        if (out_busy) begin
            out_lat--;
            if (out_lat == 0) begin
                rsp      = 1'b1;
                out_busy = 1'b0;
            end
        end
        fetch_en       = ($urandom_range(0, 99) < p_fen);
        inst_ready     = ($urandom_range(0, 99) < p_irdy);
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_rsp_valid = rsp;
        imem_rsp_data  = d;
        imem_rsp_err   = e;

        // Any redirect between acceptance and response squashes the fetch.
        if (rsp && !out_killed && !rv)
            exp_inst_q.push_back('{d, out_addr, e});
        ihs = inst_valid && inst_ready;
        // A presented instruction not taken before a redirect is discarded.
        if (rv && inst_valid && !inst_ready && exp_inst_q.size() > 0)
            void'(exp_inst_q.pop_front());
        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
            checks++;
            if (out_busy) begin
                errors++;
                $display("FAIL one_outstanding: got second request at 0x%0h expected none", imem_req_addr);
            end
            exp_addr_q.push_back(m_pc);
            out_busy   = 1'b1;
            out_lat    = $urandom_range(1, lat_max);
            out_addr   = m_pc;
            out_killed = 1'b0;
        end
        if (rv && out_busy) out_killed = 1'b1;
        exp_mis_q.push_back(rv && (rp[1:0] != 2'b00));
        if (rv)       m_pc = {rp[63:2], 2'b00};
        else if (ihs) m_pc = m_pc + 64'd4;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            step();
        end
    endtask

    // Monitor: samples just after each falling edge, after stimulus settles.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (exp_mis_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL misalign_q: got empty expectation queue expected entry");
                end else begin
                    chk("misalign", {63'd0, misalign_o}, {63'd0, exp_mis_q.pop_front()});
                end
                chk("fetch_cnt", fetch_cnt, mon_acc);
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_addr: got unexpected request 0x%0h expected none", imem_req_addr);
                    end else begin
                        logic [63:0] a;
                        a = exp_addr_q.pop_front();
                        chk("req_addr", imem_req_addr, a);
                        chk("pc_o", pc_o, a);
                    end
                end
                if (inst_valid && inst_ready) begin
                    if (exp_inst_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL inst: got unexpected instruction pc 0x%0h expected none", inst_pc);
                    end else begin
                        exp_inst_t x;
                        x = exp_inst_q.pop_front();
                        chk("inst_o", {32'd0, inst_o}, {32'd0, x.inst});
                        chk("inst_pc", inst_pc, x.pc);
                        chk("inst_fault", {63'd0, inst_fault}, {63'd0, x.fault});
                    end
                    mon_acc = mon_acc + 64'd1;
                end
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        model_reset();
        rst    = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("idle_no_req", {63'd0, imem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("first_req_cycle", {63'd0, imem_req_valid}, 64'd1);
    endtask

    initial begin
        bit found;
        rst            = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        release_reset();

        // Straight-line fetch: 0x80000000, +4, +8, ... with no stalls.
        p_redir = 0; p_rdy = 100; lat_max = 1; p_irdy = 100; p_fen = 100;
        run(12);
        chk("cnt_after_straight", {32'd0, 32'(mon_acc)} >= 64'd3 ? 64'd1 : 64'd0, 64'd1);

        // Mixed random traffic with redirects, faults, wrap-around targets.
        p_redir = 8; p_rdy = 70; lat_max = 4; p_irdy = 60; p_fen = 85;
        run(1500);

        // Long decode stalls.
        p_redir = 5; p_irdy = 10;
        run(300);

        // Asynchronous reset while a request is outstanding.
        p_redir = 0; p_rdy = 100; p_irdy = 100; p_fen = 100; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            run(1);
            found = out_busy;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_reached: got no outstanding request expected one within 200 cycles");
        end
        @(negedge clk);
        mon_en         = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        rst            = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        release_reset();

        p_redir = 10; p_rdy = 80; lat_max = 3; p_irdy = 70; p_fen = 90;
        run(600);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake. It replaces free-running PC increment with a stall-aware fetch loop. It presents fetched instructions to decode via valid/ready and accepts branch/jump redirects from execute, squashing any wrong-path fetch in flight. It sits between the IMEM port and the decode stage.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
ADDR_W, 64, PC/address width
INST_W, 32, instruction width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_en  in  1  1 = allowed to issue new IMEM requests
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  ADDR_W  redirect target
imem_req_valid  out  1  IMEM read request valid
imem_req_ready  in  1  IMEM accepts request
imem_req_addr  out  ADDR_W  request address (= pc_o)
imem_rsp_valid  in  1  IMEM read data valid (always accepted, no backpressure)
imem_rsp_data  in  INST_W  read data
imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_o  out  INST_W  instruction
inst_pc  out  ADDR_W  PC of inst_o
inst_fault  out  1  inst_o is an access-fault marker
misalign_o  out  1  one-cycle pulse: redirect_pc[1:0] != 0
pc_o  out  ADDR_W  current fetch PC
fetch_cnt  out  64  count of instructions accepted by decode

Behaviour:
- Reset (rst=0, async): state IDLE, pc_o=RESET_PC, kill=0, imem_req_valid=0, inst_valid=0, inst_o=0, inst_pc=0, inst_fault=0, misalign_o=0, fetch_cnt=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: if fetch_en, go to REQ next cycle. Earliest request is the 2nd cycle after reset release.
- REQ: imem_req_valid=1 and imem_req_addr=pc_o (combinational from state). On imem_req_ready, go to WAIT. If fetch_en=0 while in REQ, keep the request held (no retraction) until accepted.
- WAIT: on imem_rsp_valid, one of:
  - kill=1 or redirect_valid this cycle: discard the response, clear kill, go to REQ if fetch_en, else IDLE.
  - otherwise: register inst_o=data, inst_pc=pc_o, inst_fault=err, and go to HOLD.
- HOLD: inst_valid=1, outputs stable until handshake. On inst_valid & inst_ready: fetch_cnt+1 and pc_o<=pc_o+4, then go to REQ if fetch_en, else IDLE. PC add wraps modulo 2^ADDR_W.
- Response latency 1..N cycles. Minimum fetch-to-decode latency is 2 cycles from req handshake. One outstanding request max.
- Redirect has highest priority, applies in every state:
  - pc_o <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - misalign_o=1 for one cycle if redirect_pc[1:0] != 0.
- Redirect per state:
  - IDLE: pc updates only.
  - REQ without ready: request address changes next cycle, allowed on redirect only.
  - REQ with ready in the same cycle: old-address request is in flight; go to WAIT with kill=1.
  - WAIT without rsp_valid: kill=1.
  - HOLD: inst_valid drops next cycle. If inst_ready is also high, the handshake counts (fetch_cnt+1), but the next PC is the redirect target, not +4. Go to REQ/IDLE by fetch_en.
- Fault response: delivered like a normal instruction with inst_fault=1. The controller does not stop; execute is responsible for the trap redirect.
- fetch_cnt wraps at 2^64.

Decomposition:
- Shared package/define file: state encodings (IDLE=2'd0, REQ=1, WAIT=2, HOLD=3), RESET_PC default, INST_W/ADDR_W constants, PC increment constant 4.
- Single module. The FSM plus PC register is small enough that no sub-module is warranted.

Test Plan:
- Reset release, fetch_en=1, IMEM ready=1, 1-cycle response -> first req addr 0x80000000, then 0x80000004, 0x80000008. inst_pc matches each. fetch_cnt=3 after 3 accepts.
- inst_ready held 0 for 5 cycles in HOLD -> inst_o/inst_pc stable, no new imem_req_valid. After ready: next addr = +4.
- Redirect to 0x80001000 while in WAIT; response arrives 3 cycles later -> response discarded, inst_valid stays 0, next req addr 0x80001000.
- Redirect and imem_req_ready in the same REQ cycle -> in-flight response killed. Redirect and inst_ready in the same HOLD cycle -> fetch_cnt+1, next req 0x80001000.
- redirect_pc=0x80000102 -> misalign_o pulses once, next req addr 0x80000100.
- imem_rsp_err=1 -> inst_fault=1 with inst_pc of faulting address. rst asserted mid-WAIT -> all outputs reset immediately, restart at RESET_PC.
